// File: rtl/bus_request_queue.sv
// Per-processor request FIFOs feeding the shared bus arbiter. Each FIFO head is
// presented to the bus and popped on that processor's processed_request pulse.
module bus_request_queue #(
    parameter int NUM_PROC = 4,
    parameter int DEPTH    = 4,
    parameter int DEST_W   = $clog2(NUM_PROC) + 1
) (
    input  logic                                      clk,
    input  logic                                      rst_l,
    input  logic [NUM_PROC-1:0]                       enq_valid,
    input  logic [NUM_PROC-1:0][47:0]                 enq_addr,
    input  logic [NUM_PROC-1:0][DEST_W-1:0]           enq_dest,
    output logic [NUM_PROC-1:0]                       enq_ready,
    input  logic [NUM_PROC-1:0]                       processed_request,
    output logic [NUM_PROC-1:0]                       request_in_avail,
    output logic [NUM_PROC-1:0][47:0]                 addrs_in,
    output logic [NUM_PROC-1:0][DEST_W-1:0]           request_dest,
    output logic [NUM_PROC-1:0][$clog2(DEPTH):0]      occupancy,
    output logic [NUM_PROC-1:0]                       err_underflow,
    output logic [NUM_PROC-1:0]                       err_bad_dest
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    for (genvar p = 0; p < NUM_PROC; p++) begin : g_fifo
        logic [47:0]       addr_mem [DEPTH];
        logic [DEST_W-1:0] dest_mem [DEPTH];
        logic [PW-1:0]     wptr, rptr;
        logic [CW-1:0]     count;
        logic              not_full, not_empty;
        logic              accept, dest_ok, push, pop;
        logic              underflow_q, bad_dest_q;

        assign not_full  = (count != CW'(DEPTH));
        assign not_empty = (count != '0);
        assign accept    = enq_valid[p] && not_full;
        assign dest_ok   = (enq_dest[p] < DEST_W'(NUM_PROC));
        assign push      = accept && dest_ok;
        assign pop       = processed_request[p] && not_empty;

        // NOTE: async reset only for control state; all sequential state uses <=.
        always_ff @(posedge clk or negedge rst_l) begin
            if (!rst_l) begin
                wptr        <= '0;
                rptr        <= '0;
                count       <= '0;
                underflow_q <= 1'b0;
                bad_dest_q  <= 1'b0;
            end else begin
                if (push) wptr <= wptr + 1'b1;
                if (pop)  rptr <= rptr + 1'b1;
                unique case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (processed_request[p] && !not_empty) underflow_q <= 1'b1;
                if (accept && !dest_ok)                 bad_dest_q  <= 1'b1;
            end
        end

        // NOTE: storage is not reset; count gates the head so stale data is never seen.
        always_ff @(posedge clk) begin
            if (push) begin
                addr_mem[wptr] <= enq_addr[p];
                dest_mem[wptr] <= enq_dest[p];
            end
        end

        assign enq_ready[p]        = not_full;
        assign request_in_avail[p] = not_empty;
        assign addrs_in[p]         = not_empty ? addr_mem[rptr] : '0;
        assign request_dest[p]     = not_empty ? dest_mem[rptr] : '0;
        assign occupancy[p]        = count;
        assign err_underflow[p]    = underflow_q;
        assign err_bad_dest[p]     = bad_dest_q;
    end

endmodule

// File: tb/tb_bus_request_queue.sv
// Self-checking bench for bus_request_queue: directed vector table, wrap and
// reset sequences, then random traffic against a queue-based reference model.
module tb_bus_request_queue;

    localparam int NUM_PROC = 4;
    localparam int DEPTH    = 4;
    localparam int DEST_W   = 3;

    logic                              clk = 1'b0;
    logic                              rst_l;
    logic [NUM_PROC-1:0]               enq_valid;
    logic [NUM_PROC-1:0][47:0]         enq_addr;
    logic [NUM_PROC-1:0][DEST_W-1:0]   enq_dest;
    logic [NUM_PROC-1:0]               enq_ready;
    logic [NUM_PROC-1:0]               processed_request;
    logic [NUM_PROC-1:0]               request_in_avail;
    logic [NUM_PROC-1:0][47:0]         addrs_in;
    logic [NUM_PROC-1:0][DEST_W-1:0]   request_dest;
    logic [NUM_PROC-1:0][2:0]          occupancy;
    logic [NUM_PROC-1:0]               err_underflow;
    logic [NUM_PROC-1:0]               err_bad_dest;

    bus_request_queue #(.NUM_PROC(NUM_PROC), .DEPTH(DEPTH), .DEST_W(DEST_W)) dut (
        .clk(clk), .rst_l(rst_l),
        .enq_valid(enq_valid), .enq_addr(enq_addr), .enq_dest(enq_dest), .enq_ready(enq_ready),
        .processed_request(processed_request),
        .request_in_avail(request_in_avail), .addrs_in(addrs_in), .request_dest(request_dest),
        .occupancy(occupancy), .err_underflow(err_underflow), .err_bad_dest(err_bad_dest)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: one plain queue of entries per processor plus sticky flags.
    typedef struct packed {
        logic [47:0]       addr;
        logic [DEST_W-1:0] dest;
    } ent_t;
    ent_t                mq [NUM_PROC][$];
    logic [NUM_PROC-1:0] m_uf, m_bad;

    typedef struct {
        int          p;
        bit          enq;
        logic [47:0] addr;
        logic [2:0]  dest;
        bit          pop;
        int          occ;
        logic [47:0] head;
        logic [2:0]  hdest;
        logic [3:0]  avail;
        bit          rdy;
        logic [3:0]  uf;
        logic [3:0]  bad;
    } vec_t;
    vec_t vecs [13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NUM_PROC; p++) mq[p].delete();
        m_uf  = '0;
        m_bad = '0;
    endtask

    // Apply one cycle of inputs, advance the model with the pre-edge state, sample at edge+1.
    task automatic step(input logic [3:0] v, input logic [3:0][47:0] a,
                        input logic [3:0][2:0] d, input logic [3:0] pr);
        enq_valid         = v;
        enq_addr          = a;
        enq_dest          = d;
        processed_request = pr;
        for (int p = 0; p < NUM_PROC; p++) begin
            int sz;
            sz = mq[p].size();
            if (pr[p]) begin
                if (sz != 0) void'(mq[p].pop_front());
                else m_uf[p] = 1'b1;
            end
            if (v[p] && sz != DEPTH) begin
                if (int'(d[p]) < NUM_PROC) mq[p].push_back('{addr: a[p], dest: d[p]});
                else m_bad[p] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        enq_valid         = '0;
        processed_request = '0;
    endtask

    task automatic single(input int p, input bit enq, input logic [47:0] addr,
                          input logic [2:0] dest, input bit pop);
        logic [3:0]        v, pr;
        logic [3:0][47:0]  a;
        logic [3:0][2:0]   d;
        v = '0; pr = '0; a = '0; d = '0;
        v[p] = enq; pr[p] = pop; a[p] = addr; d[p] = dest;
        step(v, a, d, pr);
    endtask

    task automatic check_model();
        for (int p = 0; p < NUM_PROC; p++) begin
            int sz;
            sz = mq[p].size();
            check($sformatf("occ[%0d]", p), 64'(occupancy[p]), 64'(sz));
            check($sformatf("avail[%0d]", p), 64'(request_in_avail[p]), 64'(sz != 0));
            check($sformatf("ready[%0d]", p), 64'(enq_ready[p]), 64'(sz != DEPTH));
            check($sformatf("addr[%0d]", p), 64'(addrs_in[p]), (sz != 0) ? 64'(mq[p][0].addr) : 64'd0);
            check($sformatf("dest[%0d]", p), 64'(request_dest[p]), (sz != 0) ? 64'(mq[p][0].dest) : 64'd0);
        end
        check("err_underflow", 64'(err_underflow), 64'(m_uf));
        check("err_bad_dest", 64'(err_bad_dest), 64'(m_bad));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " occupancy"}, 64'(occupancy), 64'd0);
        check({tag, " avail"}, 64'(request_in_avail), 64'd0);
        check({tag, " addrs_in"}, 64'(addrs_in), 64'd0);
        check({tag, " request_dest"}, 64'(request_dest), 64'd0);
        check({tag, " enq_ready"}, 64'(enq_ready), 64'hF);
        check({tag, " err_underflow"}, 64'(err_underflow), 64'd0);
        check({tag, " err_bad_dest"}, 64'(err_bad_dest), 64'd0);
    endtask

    initial begin
        //            p enq addr        dst pop occ head        hd avail   rdy uf       bad
        vecs[0]  = '{1, 1, 48'h1000, 2, 0, 1, 48'h1000, 2, 4'b0010, 1, 4'b0000, 4'b0000};
        vecs[1]  = '{0, 1, 48'hA0,   1, 0, 1, 48'hA0,   1, 4'b0011, 1, 4'b0000, 4'b0000};
        vecs[2]  = '{0, 1, 48'hA1,   1, 0, 2, 48'hA0,   1, 4'b0011, 1, 4'b0000, 4'b0000};
        vecs[3]  = '{0, 1, 48'hA2,   1, 0, 3, 48'hA0,   1, 4'b0011, 1, 4'b0000, 4'b0000};
        vecs[4]  = '{0, 1, 48'hA3,   1, 0, 4, 48'hA0,   1, 4'b0011, 0, 4'b0000, 4'b0000};
        vecs[5]  = '{0, 1, 48'hA4,   1, 0, 4, 48'hA0,   1, 4'b0011, 0, 4'b0000, 4'b0000};
        vecs[6]  = '{0, 0, 48'h0,    0, 1, 3, 48'hA1,   1, 4'b0011, 1, 4'b0000, 4'b0000};
        vecs[7]  = '{2, 1, 48'hC0,   3, 0, 1, 48'hC0,   3, 4'b0111, 1, 4'b0000, 4'b0000};
        vecs[8]  = '{2, 1, 48'hC1,   3, 0, 2, 48'hC0,   3, 4'b0111, 1, 4'b0000, 4'b0000};
        vecs[9]  = '{2, 1, 48'hC2,   0, 1, 2, 48'hC1,   3, 4'b0111, 1, 4'b0000, 4'b0000};
        vecs[10] = '{2, 0, 48'h0,    0, 1, 1, 48'hC2,   0, 4'b0111, 1, 4'b0000, 4'b0000};
        vecs[11] = '{3, 0, 48'h0,    0, 1, 0, 48'h0,    0, 4'b0111, 1, 4'b1000, 4'b0000};
        vecs[12] = '{0, 1, 48'hA5,   5, 0, 3, 48'hA1,   1, 4'b0111, 1, 4'b1000, 4'b0001};

        rst_l = 1'b0;
        enq_valid = '0; enq_addr = '0; enq_dest = '0; processed_request = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_l = 1'b1;
        check_reset_values("reset");

        for (int i = 0; i < 13; i++) begin
            vec_t t;
            t = vecs[i];
            single(t.p, t.enq, t.addr, t.dest, t.pop);
            check($sformatf("v%0d occ", i), 64'(occupancy[t.p]), 64'(t.occ));
            check($sformatf("v%0d head", i), 64'(addrs_in[t.p]), 64'(t.head));
            check($sformatf("v%0d hdest", i), 64'(request_dest[t.p]), 64'(t.hdest));
            check($sformatf("v%0d avail", i), 64'(request_in_avail), 64'(t.avail));
            check($sformatf("v%0d ready", i), 64'(enq_ready[t.p]), 64'(t.rdy));
            check($sformatf("v%0d uf", i), 64'(err_underflow), 64'(t.uf));
            check($sformatf("v%0d bad", i), 64'(err_bad_dest), 64'(t.bad));
        end

        // Pointer wrap on FIFO 3: six entries through four slots with overlapped push/pop.
        for (int k = 0; k < 3; k++) single(3, 1'b1, 48'hB0 + 48'(k), 3'd0, 1'b0);
        for (int j = 0; j < 6; j++) begin
            check($sformatf("wrap head %0d", j), 64'(addrs_in[3]), 64'(48'hB0 + 48'(j)));
            check($sformatf("wrap occ %0d", j), 64'(occupancy[3]), 64'((j <= 3) ? 3 : 6 - j));
            single(3, (j < 3), 48'hB3 + 48'(j), 3'd0, 1'b1);
        end
        check("wrap drained", 64'(occupancy[3]), 64'd0);

        // Build occupancy 3,1,0,2 then reset asynchronously in the middle of a cycle.
        single(2, 1'b0, 48'h0, 3'd0, 1'b1);
        single(3, 1'b1, 48'hD0, 3'd1, 1'b0);
        single(3, 1'b1, 48'hD1, 3'd1, 1'b0);
        check("pre-reset occupancy", 64'(occupancy), 64'({3'd2, 3'd0, 3'd1, 3'd3}));
        #3 rst_l = 1'b0;
        #1 check_reset_values("async reset");
        model_reset();
        @(posedge clk);
        #1 rst_l = 1'b1;
        single(0, 1'b0, 48'h0, 3'd0, 1'b0);
        check_reset_values("post reset");
        check_model();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            logic [3:0]       v, pr;
            logic [3:0][47:0] a;
            logic [3:0][2:0]  d;
            for (int p = 0; p < NUM_PROC; p++) begin
                v[p]  = ($urandom_range(0, 99) < 55);
                pr[p] = ($urandom_range(0, 99) < 45);
                a[p]  = {16'($urandom), $urandom};
                d[p]  = ($urandom_range(0, 49) == 0) ? 3'($urandom_range(4, 7))
                                                     : 3'($urandom_range(0, 3));
            end
            step(v, a, d, pr);
            check_model();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bus_request_queue.md
Name: bus_request_queue

Overview:
- Per-processor request buffering stage directly upstream of the shared bus arbiter.
- Each processor/cache controller pushes (address, destination) requests into its own FIFO.
- The block presents each FIFO head to the bus as request_in_avail/addrs_in/request_dest.
- It pops the head when the bus returns a processed_request pulse for that processor, so requesters never stall on a busy bus until their queue fills.

Parameters:
NUM_PROC, 4, number of processors; one independent FIFO per processor
DEPTH, 4, entries per FIFO; power of two, minimum 2
DEST_W, $clog2(NUM_PROC)+1, destination field width (matches bus request_dest)

Ports:
clk  input  1  system clock
rst_l  input  1  asynchronous active-low reset
enq_valid  input  [NUM_PROC]  processor i offers a request this cycle
enq_addr  input  [NUM_PROC][47:0]  request memory address
enq_dest  input  [NUM_PROC][DEST_W-1:0]  destination processor index
enq_ready  output  [NUM_PROC]  FIFO i can accept; transfer occurs when enq_valid[i] && enq_ready[i]
processed_request  input  [NUM_PROC]  one-cycle pulse from bus: head of FIFO i was granted
request_in_avail  output  [NUM_PROC]  FIFO i non-empty (head valid)
addrs_in  output  [NUM_PROC][47:0]  head address of FIFO i
request_dest  output  [NUM_PROC][DEST_W-1:0]  head destination of FIFO i
occupancy  output  [NUM_PROC][$clog2(DEPTH):0]  entries currently held in FIFO i
err_underflow  output  [NUM_PROC]  sticky: processed_request[i] seen while FIFO i empty
err_bad_dest  output  [NUM_PROC]  sticky: enqueue attempted with enq_dest >= NUM_PROC

Behaviour:
- Reset: asynchronous on rst_l low; clears every FIFO's pointers/count and both error flags.
- Reset values: occupancy=0, request_in_avail=0, addrs_in=0, request_dest=0, err_*=0, enq_ready=all 1s.
- Reset mid-operation discards all queued entries; no pop is generated for them.
- Per-FIFO state: write pointer, read pointer ($clog2(DEPTH) bits, wrap modulo DEPTH), count (0..DEPTH). Storage is DEPTH x (48+DEST_W) per processor.
- enq_ready[i] = (count[i] != DEPTH). It is purely a function of registered count and does not look ahead at a same-cycle pop.
- Enqueue: on posedge clk with enq_valid[i] && enq_ready[i] && enq_dest[i] < NUM_PROC:
  - write {enq_addr, enq_dest} at wptr;
  - wptr += 1 (wraps DEPTH-1 -> 0);
  - count += 1.
- Bad destination: enq_valid[i] && enq_ready[i] && enq_dest[i] >= NUM_PROC → entry dropped, err_bad_dest[i] set. The handshake still completes, so the requester does not hang.
- Head outputs are combinational from storage[rptr] gated by count != 0:
  - request_in_avail[i] = (count[i] != 0);
  - addrs_in/request_dest driven 0 when empty.
- Latency: an entry enqueued at edge N is visible on the head outputs in the cycle after edge N (1-cycle enqueue-to-avail). There is no bypass from enq inputs to head outputs.
- Dequeue: on posedge clk with processed_request[i] && count[i] != 0 → rptr += 1 (wrap), count -= 1. The new head appears in the following cycle.
- processed_request[i] with count 0 → no state change, err_underflow[i] set.
- Same-cycle enqueue and dequeue on one FIFO (count between 1 and DEPTH-1) → both occur, count unchanged, pointers both advance.
- At count == DEPTH, enq_ready is 0, so a same-cycle dequeue frees a slot visible only in the next cycle.
- FIFOs are fully independent: any combination of processors may enqueue/dequeue on the same edge.
- Error flags are sticky until reset.
- Bus contract: the bus holds its grant for its transfer time and issues processed_request one cycle after sampling. This block keeps the old head asserted during that cycle, and the bus ignores it while held. No extra issued-guard is required.
- Ordering: strict FIFO per processor; no ordering guarantee across processors (arbitration is the bus's job).

Test Plan:
1. Reset, then enq on proc 1 {addr=0x1000, dest=2} at edge 1 → cycle after: request_in_avail=4'b0010, addrs_in[1]=0x1000, request_dest[1]=2, occupancy[1]=1.
2. Fill proc 0 with 4 entries (addr 0xA0..0xA3) → enq_ready[0]=0, occupancy[0]=4. Fifth enq_valid holds with no write. Pulse processed_request[0] → head becomes 0xA1, occupancy 3, enq_ready[0]=1 next cycle.
3. Cycle 6 entries through a DEPTH=4 FIFO with interleaved pops → dequeue order 0xB0..0xB5 exactly, confirming pointer wrap.
4. occupancy[2]=2; simultaneous enq {0xC2, dest 0} and processed_request[2] → occupancy stays 2, head advances to second entry, new entry lands at tail.
5. processed_request[3] pulse with FIFO 3 empty → err_underflow=4'b1000, occupancy unchanged. Enq with dest=5 (NUM_PROC=4) on proc 0 → err_bad_dest[0]=1, occupancy[0] unchanged.
6. Queues partially full (occupancy 3,1,0,2), assert rst_l low asynchronously mid-cycle → all outputs immediately at reset values. After release, no stale entries are presented.
